// File: rtl/uart_tx_unit.sv
// rtl/uart_tx_unit.sv - buffered UART transmitter: FIFO, 16x baud divider, frame FSM.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_unit #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 651,
  parameter int DVSR_W  = 10,
  parameter int FIFO_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  output logic            tx,
  output logic            tx_full,
  output logic            tx_busy
);
  localparam int DEPTH = 2**FIFO_W;
  localparam int S_W   = $clog2(SB_TICK + 16);
  localparam int N_W   = $clog2(DBIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state_q;
  logic [DVSR_W-1:0] baud_q;
  logic              tick;
  logic [S_W-1:0]    s_q;
  logic [N_W-1:0]    n_q;
  logic [DBIT-1:0]   shift_q;
  logic [DBIT-1:0]   shift_nxt;
  logic              tx_q;
  logic              busy_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [FIFO_W-1:0] wptr_q, wptr_d;
  logic [FIFO_W-1:0] rptr_q, rptr_d;
  logic [FIFO_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              push, pop, empty;
  logic [DBIT-1:0]   head;

  // A full FIFO drops the write even when the FSM pops in the same cycle.
  assign empty     = (count_q == '0);
  assign push      = wr_uart && !full_q;
  assign pop       = (state_q == IDLE) && !empty;
  assign head      = mem_q[rptr_q];
  assign tick      = (baud_q == DVSR_W'(DVSR - 1));
  assign shift_nxt = shift_q >> 1;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == (FIFO_W + 1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= w_data;
  end

  // Restarting the divider on the pop aligns every bit to a full 16xDVSR period.
  always_ff @(posedge clk) begin
    if (reset)            baud_q <= '0;
    else if (pop || tick) baud_q <= '0;
    else                  baud_q <= baud_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift_q  <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            s_q      <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (tick) begin
            if (s_q == S_W'(15)) begin
              s_q     <= '0;
              n_q     <= '0;
              tx_q    <= shift_q[0];
              state_q <= DATA;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_q == S_W'(15)) begin
              s_q     <= '0;
              shift_q <= shift_nxt;
              if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= parity_q;
                state_q <= PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= STOP;
`endif
              end else begin
                n_q  <= n_q + 1'b1;
                tx_q <= shift_nxt[0];
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s_q == S_W'(15)) begin
              s_q     <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s_q == S_W'(SB_TICK - 1)) begin
              s_q     <= '0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_full = full_q;
  assign tx_busy = busy_q;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb/tb_uart_tx_unit.sv - scoreboard bench for uart_tx_unit at DVSR=4 (64 cycles per bit).
module tb_uart_tx_unit;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int DVSR    = 4;
  localparam int DVSR_W  = 3;
  localparam int FIFO_W  = 2;
  localparam int BIT_CYC = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int NB = 1 + DBIT + PBITS + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            tx;
  logic            tx_full;
  logic            tx_busy;

  uart_tx_unit #(
    .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .DVSR_W(DVSR_W), .FIFO_W(FIFO_W)
  ) dut (
    .clk(clk), .reset(reset), .wr_uart(wr_uart), .w_data(w_data),
    .tx(tx), .tx_full(tx_full), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [DBIT-1:0] sb_q[$];
  int start_q[$];
  int frames_done = 0;
  logic mon_active = 1'b0;
  int mon_cyc = 0;
  logic [NB-1:0] mon_exp;
  logic [DBIT-1:0] mon_rx;
  logic [DBIT-1:0] mon_byte;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [NB-1:0] frame_bits(input logic [DBIT-1:0] d);
    logic [NB-1:0] fb;
    fb = '0;
    fb[DBIT:1] = d;
`ifdef UART_TX_PARITY_EN
    fb[DBIT+1] = ^d;
`endif
    fb[NB-1] = 1'b1;
    return fb;
  endfunction

  // Line monitor: decodes each frame and checks it against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cyc = 0;
          start_q.push_back(cyc);
          check_eq("frame_expected", 32'(sb_q.size() > 0), 1);
          mon_byte = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
          mon_exp = frame_bits(mon_byte);
          mon_rx = '0;
        end
      end else begin
        mon_cyc++;
      end
      if (mon_active) begin
        int b;
        int off;
        b = mon_cyc / BIT_CYC;
        off = mon_cyc % BIT_CYC;
        if (off == 0 || off == BIT_CYC - 1) begin
          check_eq("tx_bit_level", 32'(tx), 32'(mon_exp[b]));
          check_eq("busy_in_frame", 32'(tx_busy), 1);
        end
        if (off == BIT_CYC / 2 && b >= 1 && b <= DBIT) mon_rx[b-1] = tx;
        if (mon_cyc == NB * BIT_CYC - 1) begin
          check_eq("frame_data", 32'(mon_rx), 32'(mon_byte));
          frames_done++;
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic push_byte(input logic [DBIT-1:0] d, input bit accept, output int c);
    @(posedge clk);
    #1;
    wr_uart = 1'b1;
    w_data = d;
    c = cyc;
    if (accept) sb_q.push_back(d);
  endtask

  task automatic end_writes();
    @(posedge clk);
    #1;
    wr_uart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || mon_active || tx_busy !== 1'b0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < 20000), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int bad;
    int fd0;
    int fs;
    reset = 1'b1;
    wr_uart = 1'b0;
    w_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_tx", 32'(tx), 1);
    check_eq("reset_busy", 32'(tx_busy), 0);
    check_eq("reset_full", 32'(tx_full), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check_eq("idle_hold", 32'(bad), 0);

    start_q.delete();
    push_byte(8'hA5, 1, c);
    end_writes();
    wait_done("a5_done");
    check_eq("a5_frame_count", 32'(start_q.size()), 1);
    if (start_q.size() > 0) check_eq("a5_start_latency", 32'(start_q[0] - c), 2);

    start_q.delete();
    push_byte(8'h00, 1, c);
    push_byte(8'hFF, 1, c);
    push_byte(8'h3C, 1, c);
    end_writes();
    wait_done("b2b_done");
    check_eq("b2b_frame_count", 32'(start_q.size()), 3);
    if (start_q.size() == 3) begin
      check_eq("b2b_gap_1", 32'(start_q[1] - start_q[0]), 32'(NB * BIT_CYC + 1));
      check_eq("b2b_gap_2", 32'(start_q[2] - start_q[1]), 32'(NB * BIT_CYC + 1));
    end

    fd0 = frames_done;
    for (int i = 0; i < 6; i++) push_byte(8'h51 + 8'(i * 17), (i < 5), c);
    end_writes();
    @(negedge clk);
    check_eq("burst_full", 32'(tx_full), 1);
    wait_done("burst_done");
    check_eq("burst_frames", 32'(frames_done - fd0), 5);
    check_eq("burst_full_clear", 32'(tx_full), 0);

    fd0 = frames_done;
    push_byte(8'h96, 1, c);
    push_byte(8'h69, 0, c);
    end_writes();
    bad = 0;
    while (!(mon_active && mon_cyc >= 4 * BIT_CYC + 20) && bad < 2000) begin
      @(negedge clk);
      bad++;
    end
    check_eq("reset_mid_reached", 32'(bad < 2000), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("midreset_tx", 32'(tx), 1);
    check_eq("midreset_busy", 32'(tx_busy), 0);
    check_eq("midreset_full", 32'(tx_full), 0);
    fs = start_q.size();
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check_eq("midreset_quiet", 32'(bad), 0);
    check_eq("midreset_no_frame", 32'(start_q.size()), 32'(fs));
    check_eq("midreset_no_complete", 32'(frames_done), 32'(fd0));

    fd0 = frames_done;
    push_byte(8'h07, 1, c);
    push_byte(8'h03, 1, c);
    end_writes();
    wait_done("parity_done");
    check_eq("parity_frames", 32'(frames_done - fd0), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
